// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: memory op encoding,
// FSM states and address-alignment predicates.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need a[0]==0, word ops need a[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return |a;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store data replication and byte enables,
// plus load lane extraction with sign/zero extension.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_val
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata >> {addr_lo, 3'b000});
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = 32'h0;
    wstrb = 4'b0000;
    case (op)
      MEM_SB: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      MEM_SH: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << addr_lo;
      end
      MEM_SW: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_val = 32'h0;
    case (op)
      MEM_LB:  load_val = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: load_val = {24'h0, byte_lane};
      MEM_LH:  load_val = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: load_val = {16'h0, half_lane};
      MEM_LW:  load_val = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one op from execute, runs it over the req/gnt/rvalid
// data bus (or passes the ALU result through) and emits a one-cycle writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  mem_op_t     mem_op,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t  state_q, state_d;
  mem_op_t     op_q;
  logic [31:0] addr_q, data_q, result_q, result_d;
  logic [4:0]  rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        merr_q, merr_d, berr_q, berr_d, capture;
  logic        timeout;
  logic [31:0] al_wdata, load_val;
  logic [3:0]  al_wstrb;

  load_store_unit_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (data_q),
    .rdata      (dmem_rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_val   (load_val)
  );

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      op_q     <= MEM_NONE;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      rd_q     <= 5'h0;
      cnt_q    <= '0;
      result_q <= 32'h0;
      merr_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      merr_q   <= merr_d;
      berr_q   <= berr_d;
      if (capture) begin
        op_q   <= mem_op;
        addr_q <= alu_result;
        data_q <= store_data;
        rd_q   <= rd_in;
      end
    end
  end

  // Completion on the last allowed cycle beats the timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    merr_d   = merr_q;
    berr_d   = berr_q;
    capture  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (valid_in) begin
          capture  = 1'b1;
          result_d = 32'h0;
          merr_d   = 1'b0;
          berr_d   = 1'b0;
          if (mem_op == MEM_NONE) begin
            state_d  = LSU_RESP;
            result_d = alu_result;
          end else if (is_misaligned(mem_op, alu_result[1:0])) begin
            state_d = LSU_RESP;
            merr_d  = 1'b1;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_gnt) begin
          if (is_store(op_q)) begin
            state_d  = LSU_RESP;
            result_d = 32'h0;
          end else if (dmem_rvalid) begin
            state_d  = LSU_RESP;
            result_d = load_val;
          end else begin
            state_d = LSU_WAIT;
          end
        end else if (timeout) begin
          state_d  = LSU_RESP;
          berr_d   = 1'b1;
          result_d = 32'h0;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_rvalid) begin
          state_d  = LSU_RESP;
          result_d = load_val;
        end else if (timeout) begin
          state_d  = LSU_RESP;
          berr_d   = 1'b1;
          result_d = 32'h0;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    ready_out    = (state_q == LSU_IDLE);
    valid_out    = (state_q == LSU_RESP);
    result       = result_q;
    rd_out       = rd_q;
    misalign_err = valid_out & merr_q;
    bus_err      = valid_out & berr_q;
    dmem_req     = (state_q == LSU_REQ);
    dmem_we      = dmem_req & is_store(op_q);
    dmem_addr    = {addr_q[31:2], 2'b00};
    dmem_wdata   = dmem_req ? al_wdata : 32'h0;
    dmem_wstrb   = dmem_req ? al_wstrb : 4'b0000;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: passthrough, loads, stores,
// misalignment, bus timeout and mid-transaction reset.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  mem_op_t     mem_op = MEM_NONE;
  logic [31:0] alu_result = 32'h0, store_data = 32'h0;
  logic [4:0]  rd_in = 5'h0;
  logic        ready_out, valid_out, misalign_err, bus_err;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_op(mem_op),
    .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
    .ready_out(ready_out), .valid_out(valid_out), .result(result), .rd_out(rd_out),
    .misalign_err(misalign_err), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold valid_in until accepted; returns #1 after the accept edge.
  task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd);
    int budget = 50;
    while (!ready_out && budget > 0) begin
      step();
      budget--;
    end
    check("ready_before_issue", 32'(ready_out), 32'h1);
    valid_in = 1'b1; mem_op = op; alu_result = a; store_data = d; rd_in = rd;
    step();
    valid_in = 1'b0; mem_op = MEM_NONE;
  endtask

  // Load completed by gnt+rvalid in the first REQ cycle.
  task automatic fast_load(input string tag, input mem_op_t op, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
    issue(op, a, 32'h0, 5'd7);
    check({tag, "_req"}, 32'(dmem_req), 32'h1);
    check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, "_wstrb"}, 32'(dmem_wstrb), 32'h0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    check({tag, "_valid"}, 32'(valid_out), 32'h1);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, 32'(rd_out), 32'd7);
    step();
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(ready_out), 32'h1);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_rd", 32'(rd_out), 32'h0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'h0);
    rst = 1'b0;
    step();

    // Passthrough
    issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd5);
    check("pass_valid", 32'(valid_out), 32'h1);
    check("pass_result", result, 32'h0000_1234);
    check("pass_rd", 32'(rd_out), 32'd5);
    check("pass_req", 32'(dmem_req), 32'h0);
    check("pass_ready", 32'(ready_out), 32'h0);
    step();
    check("pass_valid_drop", 32'(valid_out), 32'h0);
    check("pass_ready_back", 32'(ready_out), 32'h1);

    // Loads
    fast_load("lb", MEM_LB, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    fast_load("lbu", MEM_LBU, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    fast_load("lh", MEM_LH, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF);
    fast_load("lhu", MEM_LHU, 32'h102, 32'h80FF_0000, 32'h0000_80FF);
    fast_load("lb0", MEM_LB, 32'h100, 32'h0000_007F, 32'h0000_007F);

    // SH with grant held off for 3 cycles
    issue(MEM_SH, 32'h202, 32'hDEAD_BEEF, 5'd9);
    for (int i = 0; i < 3; i++) begin
      check("sh_req_held", 32'(dmem_req), 32'h1);
      check("sh_addr_held", dmem_addr, 32'h200);
      check("sh_wdata_held", dmem_wdata, 32'hBEEF_BEEF);
      step();
    end
    check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh_we", 32'(dmem_we), 32'h1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("sh_valid", 32'(valid_out), 32'h1);
    check("sh_result", result, 32'h0);
    check("sh_req_drop", 32'(dmem_req), 32'h0);
    step();

    // SB lane replication and strobe
    issue(MEM_SB, 32'h301, 32'h0000_00A5, 5'd3);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
    check("sb_addr", dmem_addr, 32'h300);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("sb_valid", 32'(valid_out), 32'h1);
    step();

    // Misaligned word load
    issue(MEM_LW, 32'h1001, 32'h0, 5'd4);
    check("mis_valid", 32'(valid_out), 32'h1);
    check("mis_err", 32'(misalign_err), 32'h1);
    check("mis_result", result, 32'h0);
    check("mis_req", 32'(dmem_req), 32'h0);
    step();
    check("mis_req_after", 32'(dmem_req), 32'h0);
    check("mis_err_drop", 32'(misalign_err), 32'h0);

    // Timeout: gnt without rvalid, abort after 8 REQ+WAIT cycles
    issue(MEM_LW, 32'h400, 32'h0, 5'd6);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("to_no_valid", 32'(valid_out), 32'h0);
      step();
    end
    check("to_valid", 32'(valid_out), 32'h1);
    check("to_bus_err", 32'(bus_err), 32'h1);
    check("to_result", result, 32'h0);
    check("to_req", 32'(dmem_req), 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    check("late_rvalid_ignored", 32'(valid_out), 32'h0);
    step();
    dmem_rvalid = 1'b0;
    check("late_rvalid_idle", 32'(valid_out), 32'h0);
    fast_load("after_to", MEM_LW, 32'h400, 32'h1234_5678, 32'h1234_5678);

    // Reset while waiting for rvalid
    issue(MEM_LW, 32'h500, 32'h0, 5'd8);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("wait_ready", 32'(ready_out), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(dmem_req), 32'h0);
    check("rst_mid_ready", 32'(ready_out), 32'h1);
    check("rst_mid_valid", 32'(valid_out), 32'h0);
    #1;
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_valid", 32'(valid_out), 32'h0);
    end
    dmem_rvalid = 1'b0;
    issue(MEM_NONE, 32'h0000_0ABC, 32'h0, 5'd1);
    check("recover_result", result, 32'h0000_0ABC);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
